// File: rtl/uart_rx_apb_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_apb_ctrl
// APB slave front end for the UART receiver core. It enables the receiver,
// captures every completed byte into a small FIFO and hands bytes back on APB
// reads. A DATA read that finds the FIFO empty is stalled with PREADY wait
// states until a byte arrives or the read timeout expires.
//
// Ports
//   PCLK, PRESETn      clock (rising edge) and synchronous active-low reset
//   PSEL, PENABLE      APB select / access-phase enable
//   PWRITE, PADDR      transfer direction and byte address
//   PWDATA             write data
//   PRDATA             read data, meaningful while PREADY=1
//   PREADY, PSLVERR    transfer complete / error response
//   rx_done_i          receiver byte-complete flag (rising edge pushes a byte)
//   rx_byte_i          receiver parallel byte, captured on the push edge
//   rx_en_o            receiver enable (CTRL.RXEN)
//   irq_o              registered interrupt: IRQEN & (NEMPTY | OVR)
//
// Register map
//   0x00 DATA    R: pop FIFO head            W: error, no effect
//   0x04 STATUS  R: {5'b0, OVR, FULL, NEMPTY} W: bit2=1 clears OVR
//   0x08 CTRL    R/W: bit0 RXEN, bit1 IRQEN; bit2 FLUSH (write-1, reads 0)
//   other        error response, reads 0, no side effects
// -----------------------------------------------------------------------------
module uart_rx_apb_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_TIMEOUT = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   input  logic       rx_done_i,
   input  logic [7:0] rx_byte_i,
   output logic       rx_en_o,
   output logic       irq_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int WC_W  = $clog2(RD_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [WC_W-1:0]  TMO_C   = WC_W'(RD_TIMEOUT);

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_CTRL   = 8'h08;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_WAIT_RX = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WC_W-1:0]   wcnt_r;
   logic              wcnt_clr_s;
   logic              wcnt_inc_s;

   logic              rxen_r;
   logic              irqen_r;
   logic              ovr_r;
   logic              irq_r;
   logic              rx_done_q_r;

   logic [7:0]        mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   logic              nempty_s;
   logic              full_s;
   logic [7:0]        head_s;
   logic [7:0]        status_s;
   logic [7:0]        ctrl_s;
   logic              rx_rise_s;
   logic              push_s;
   logic              push_ok_s;
   logic              overrun_s;
   logic              pop_s;
   logic              flush_s;
   logic              wr_status_s;
   logic              wr_ctrl_s;
   logic              pready_s;
   logic              pslverr_s;
   logic [7:0]        prdata_s;
   logic              unused_pwdata_s;

   assign nempty_s  = (count_r != {CNT_W{1'b0}});
   assign full_s    = (count_r == DEPTH_C);
   assign head_s    = mem_r[rd_ptr_r];
   assign status_s  = {5'b00000, ovr_r, full_s, nempty_s};
   assign ctrl_s    = {6'b000000, irqen_r, rxen_r};

   // Only the first edge of a long rx_done_i level produces a push.
   assign rx_rise_s = rx_done_i & ~rx_done_q_r;
   assign push_s    = rx_rise_s & rxen_r;
   assign flush_s   = wr_ctrl_s & PWDATA[2];
   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign push_ok_s = push_s & (~full_s | pop_s);
   // Flush discards the incoming byte outright, so it never counts as an overrun.
   assign overrun_s = push_s & full_s & ~pop_s & ~flush_s;

   assign unused_pwdata_s = ^PWDATA[7:3];

   assign PREADY  = pready_s;
   assign PSLVERR = pslverr_s;
   assign PRDATA  = prdata_s;
   assign rx_en_o = rxen_r;
   assign irq_o   = irq_r;

   // Bus FSM: next state, combinational APB response and register strobes.
   always_comb begin
      state_nxt_s = state_r;
      pready_s    = 1'b0;
      pslverr_s   = 1'b0;
      prdata_s    = 8'h00;
      pop_s       = 1'b0;
      wr_status_s = 1'b0;
      wr_ctrl_s   = 1'b0;
      wcnt_clr_s  = 1'b0;
      wcnt_inc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (!PSEL) begin
               state_nxt_s = ST_IDLE;
            end else if (PENABLE) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_SETUP;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               state_nxt_s = ST_IDLE;
            end else if (!PWRITE && (PADDR == ADDR_DATA) && !nempty_s) begin
               // Nothing to return yet: hold the bus until a byte shows up.
               state_nxt_s = ST_WAIT_RX;
               wcnt_clr_s  = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
               pready_s    = 1'b1;
               case (PADDR)
                  ADDR_DATA: begin
                     if (PWRITE) begin
                        pslverr_s = 1'b1;
                     end else begin
                        prdata_s = head_s;
                        pop_s    = 1'b1;
                     end
                  end
                  ADDR_STATUS: begin
                     if (PWRITE) begin
                        wr_status_s = 1'b1;
                     end else begin
                        prdata_s = status_s;
                     end
                  end
                  ADDR_CTRL: begin
                     if (PWRITE) begin
                        wr_ctrl_s = 1'b1;
                     end else begin
                        prdata_s = ctrl_s;
                     end
                  end
                  default: begin
                     pslverr_s = 1'b1;
                  end
               endcase
            end
         end
         ST_WAIT_RX: begin
            if (!PSEL) begin
               state_nxt_s = ST_IDLE;
            end else if (nempty_s) begin
               state_nxt_s = ST_IDLE;
               pready_s    = 1'b1;
               prdata_s    = head_s;
               pop_s       = 1'b1;
            end else if (wcnt_r == TMO_C) begin
               state_nxt_s = ST_IDLE;
               pready_s    = 1'b1;
               pslverr_s   = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT_RX;
               wcnt_inc_s  = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register and read-stall wait counter.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_r <= ST_IDLE;
         wcnt_r  <= {WC_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (wcnt_clr_s) begin
            wcnt_r <= {WC_W{1'b0}};
         end else if (wcnt_inc_s) begin
            wcnt_r <= wcnt_r + WC_W'(1);
         end
      end
   end

   // Control/status registers, rx_done_i edge detector and interrupt output.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rxen_r      <= 1'b0;
         irqen_r     <= 1'b0;
         ovr_r       <= 1'b0;
         irq_r       <= 1'b0;
         rx_done_q_r <= 1'b0;
      end else begin
         rx_done_q_r <= rx_done_i;
         irq_r       <= irqen_r & (nempty_s | ovr_r);
         if (wr_ctrl_s) begin
            rxen_r  <= PWDATA[0];
            irqen_r <= PWDATA[1];
         end
         // A fresh overrun in the clearing cycle wins so it is never lost.
         if (overrun_s) begin
            ovr_r <= 1'b1;
         end else if (wr_status_s && PWDATA[2]) begin
            ovr_r <= 1'b0;
         end
      end
   end

   // Receive FIFO storage, pointers and occupancy count.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= rx_byte_i;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if (push_ok_s && !pop_s) begin
            count_r <= count_r + CNT_W'(1);
         end else if (pop_s && !push_ok_s) begin
            count_r <= count_r - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_apb_ctrl: APB tasks push the expected
// completion into a queue, a negedge monitor pops and compares on PREADY.
module tb_uart_rx_apb_ctrl;

   localparam int FIFO_DEPTH = 4;
   localparam int RD_TIMEOUT = 16;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       PSEL = 1'b0;
   logic       PENABLE = 1'b0;
   logic       PWRITE = 1'b0;
   logic [7:0] PADDR = 8'h00;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic       rx_done_i = 1'b0;
   logic [7:0] rx_byte_i = 8'h00;
   logic       rx_en_o;
   logic       irq_o;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
      logic       chk;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   uart_rx_apb_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .rx_done_i(rx_done_i),
      .rx_byte_i(rx_byte_i), .rx_en_o(rx_en_o), .irq_o(irq_o)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every completed transfer must match the oldest expectation.
   always @(negedge PCLK) begin : monitor
      exp_t e;
      if (PRESETn && PSEL && PENABLE && PREADY === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: PRDATA 0x%0h PSLVERR %0b with nothing expected", PRDATA, PSLVERR);
         end else begin
            e = exp_q.pop_front();
            check("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
            if (e.chk) check("prdata", {24'd0, PRDATA}, {24'd0, e.rdata});
         end
      end
   end

   // Full APB transfer; waits = PREADY=0 cycles after the SETUP-state cycle.
   task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp_rd, input logic exp_err, output int waits);
      exp_t e;
      bit   done;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.chk   = ~wr;
      exp_q.push_back(e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge PCLK);
         if (PREADY === 1'b1) begin
            done = 1'b1;
         end else begin
            waits++;
            @(posedge PCLK); #1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL apb_timeout: addr 0x%0h got no PREADY within 64 cycles", addr);
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input logic err);
      int w;
      apb(1'b0, addr, 8'h00, exp, err, w);
      check("rd_waits", w, 0);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic err);
      int w;
      apb(1'b1, addr, data, 8'h00, err, w);
      check("wr_waits", w, 0);
   endtask

   // rx_done_i pulse; the push happens at the second edge of this task.
   task automatic rx_push(input logic [7:0] b);
      @(posedge PCLK); #1;
      rx_byte_i = b; rx_done_i = 1'b1;
      @(posedge PCLK); #1;
      rx_done_i = 1'b0;
   endtask

   // Pulse timed so the push edge coincides with the completion edge of an
   // apb() call started at the same moment (setup, enable, access, complete).
   task automatic rx_push_at_completion(input logic [7:0] b);
      repeat (3) @(posedge PCLK);
      #1;
      rx_byte_i = b; rx_done_i = 1'b1;
      @(posedge PCLK); #1;
      rx_done_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int w;
      // T1 reset
      PRESETn = 1'b0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_prdata", {24'd0, PRDATA}, 32'h0);
      check("rst_pready", {31'd0, PREADY}, 32'h0);
      check("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
      check("rst_rx_en", {31'd0, rx_en_o}, 32'h0);
      check("rst_irq", {31'd0, irq_o}, 32'h0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      rd(8'h04, 8'h00, 1'b0);
      rd(8'h08, 8'h00, 1'b0);

      // T2 basic receive with interrupt
      wr(8'h08, 8'h03, 1'b0);
      check("rx_en_on", {31'd0, rx_en_o}, 32'h1);
      rx_push(8'hA5);
      @(negedge PCLK);
      check("irq_push_cycle", {31'd0, irq_o}, 32'h0);
      @(negedge PCLK);
      check("irq_next_cycle", {31'd0, irq_o}, 32'h1);
      rd(8'h00, 8'hA5, 1'b0);
      rd(8'h04, 8'h00, 1'b0);

      // T3 overrun: fifth byte dropped; OVR, FULL and NEMPTY all set
      for (int i = 1; i <= 5; i++) rx_push(8'(i));
      rd(8'h04, 8'h07, 1'b0);
      for (int i = 1; i <= 4; i++) rd(8'h00, 8'(i), 1'b0);
      rd(8'h04, 8'h04, 1'b0);
      wr(8'h04, 8'h04, 1'b0);
      rd(8'h04, 8'h00, 1'b0);

      // T4 stalled read: ACCESS cycle + 4 WAIT_RX cycles before the push edge,
      // PREADY in the cycle right after it
      fork
         apb(1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, w);
         begin
            repeat (7) @(posedge PCLK);
            #1;
            rx_byte_i = 8'h3C; rx_done_i = 1'b1;
            @(posedge PCLK); #1;
            rx_done_i = 1'b0;
         end
      join
      check("stall_waits", w, 5);
      rd(8'h04, 8'h00, 1'b0);

      // T5 timeout: ACCESS cycle finding the FIFO empty + RD_TIMEOUT WAIT_RX cycles
      apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, w);
      check("timeout_waits", w, RD_TIMEOUT + 1);

      // T6a push and pop in the same cycle at count 2
      rx_push(8'h11);
      rx_push(8'h22);
      fork
         apb(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, w);
         rx_push_at_completion(8'h33);
      join
      rd(8'h04, 8'h01, 1'b0);
      rd(8'h00, 8'h22, 1'b0);
      rd(8'h00, 8'h33, 1'b0);
      rd(8'h04, 8'h00, 1'b0);

      // T6b FLUSH together with a push: flush wins, FLUSH reads back 0
      rx_push(8'h44);
      fork
         apb(1'b1, 8'h08, 8'h07, 8'h00, 1'b0, w);
         rx_push_at_completion(8'h55);
      join
      rd(8'h04, 8'h00, 1'b0);
      rd(8'h08, 8'h03, 1'b0);

      // T6c error responses and a DATA write without side effects
      wr(8'h10, 8'h5A, 1'b1);
      rd(8'h0C, 8'h00, 1'b1);
      wr(8'h00, 8'h77, 1'b1);
      rd(8'h04, 8'h00, 1'b0);

      // Clearing RXEN keeps contents and ignores new edges
      rx_push(8'h66);
      wr(8'h08, 8'h02, 1'b0);
      check("rx_en_off", {31'd0, rx_en_o}, 32'h0);
      rx_push(8'h77);
      rd(8'h04, 8'h01, 1'b0);
      rd(8'h00, 8'h66, 1'b0);
      rd(8'h04, 8'h00, 1'b0);

      // T6d reset while stalled in WAIT_RX: transfer dropped, no completion
      wr(8'h08, 8'h03, 1'b0);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      repeat (4) @(posedge PCLK);
      @(negedge PCLK);
      check("wait_pready", {31'd0, PREADY}, 32'h0);
      check("wait_rx_en", {31'd0, rx_en_o}, 32'h1);
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("post_rst_pready", {31'd0, PREADY}, 32'h0);
      check("post_rst_rx_en", {31'd0, rx_en_o}, 32'h0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      rd(8'h04, 8'h00, 1'b0);
      rd(8'h08, 8'h00, 1'b0);

      repeat (2) @(posedge PCLK);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
